// File: rtl/knn_buf_pkg.sv
// knn_buf_pkg
//   Shared types and constants for the partialKnn local search-space buffer
//   (256b x 2048 URAM) and the stage that fills it.
//   Contents:
//     knn_state_e      loader FSM state {IDLE, RECV, HI, FIN}
//     KNN_BUF_WORD_W   buffer word width
//     KNN_BUF_DEPTH    buffer depth in words
//     KNN_BUF_AW       buffer address width
//     KNN_BEAT_W       upstream beat width (two buffer words)
//     KNN_CNT_W        width of word counts 0..KNN_BUF_DEPTH
package knn_buf_pkg;

    localparam int KNN_BUF_WORD_W = 256;
    localparam int KNN_BUF_DEPTH  = 2048;
    localparam int KNN_BUF_AW     = 11;
    localparam int KNN_BEAT_W     = 512;
    localparam int KNN_CNT_W      = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HI   = 2'd2,
        FIN  = 2'd3
    } knn_state_e;

endpackage

// File: rtl/knn_local_buf_loader.sv
// knn_local_buf_loader
//   Fill stage for the partialKnn local search-space buffer. Accepts 512-bit
//   beats from the upstream reader, splits each into two 256-bit words
//   (low half first) and writes them to consecutive buffer addresses from 0.
//   A one-cycle done pulse tells the compute stage the buffer is loaded.
//
//   Optional feature: define KNN_LOADER_CHECKSUM_EN to add a checksum output
//   (XOR of every word written since the last start).
//
// Ports
//   clk            clock, rising edge
//   reset          synchronous, active-low
//   start          one-cycle pulse; latches num_words; honoured only from IDLE
//   num_words      words to write, 0..2048 (larger values clamp to 2048)
//   in_data        beat; low word = [DataWidth-1:0], high word above it
//   in_valid       beat valid
//   in_ready       beat ready (high only in RECV)
//   mem_address0   buffer write address (registered)
//   mem_ce0        buffer enable, equal to mem_we0 (registered)
//   mem_we0        buffer write enable (registered)
//   mem_d0         buffer write data (registered)
//   busy           high from the cycle after an accepted start through done
//   done           one-cycle completion pulse
//   words_written  words written since the last start; holds after done
//   checksum       (KNN_LOADER_CHECKSUM_EN only) XOR of written words
//   state_dbg      current FSM state, for debug and checkers
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready.
// Upstream must hold in_data stable while in_valid is high and the beat has
// not transferred; in_ready does not depend on in_valid.
//
// IN_WIDTH must equal 2*DataWidth.
module knn_local_buf_loader
    import knn_buf_pkg::*;
#(
    parameter int IN_WIDTH  = KNN_BEAT_W,
    parameter int DataWidth = KNN_BUF_WORD_W,
    parameter int AddrWidth = KNN_BUF_AW,
    parameter int AddrRange = KNN_BUF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [KNN_CNT_W-1:0]     num_words,
    input  logic [IN_WIDTH-1:0]      in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [AddrWidth-1:0]     mem_address0,
    output logic                     mem_ce0,
    output logic                     mem_we0,
    output logic [DataWidth-1:0]     mem_d0,
    output logic                     busy,
    output logic                     done,
    output logic [KNN_CNT_W-1:0]     words_written,
`ifdef KNN_LOADER_CHECKSUM_EN
    output logic [DataWidth-1:0]     checksum,
`endif
    output knn_state_e               state_dbg
);

    knn_state_e             state;
    knn_state_e             state_next;
    logic [KNN_CNT_W-1:0]   rem;
    logic [AddrWidth-1:0]   wr_ptr;
    logic [DataWidth-1:0]   hold;
    logic                   wr_en;
    logic [DataWidth-1:0]   wr_data;
    logic                   hs;
    logic                   start_acc;
    logic [KNN_CNT_W-1:0]   num_clamped;

    assign state_dbg = state;
    assign hs        = in_valid && in_ready;

    // done is registered, so while it is high the FSM is already back in
    // IDLE; gating on it drops a start that coincides with the done pulse.
    assign start_acc = start && (state == IDLE) && !done;

    assign num_clamped = (num_words > KNN_CNT_W'(AddrRange)) ?
                         KNN_CNT_W'(AddrRange) : num_words;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_acc) begin
                    state_next = (num_words == '0) ? FIN : RECV;
                end
            end
            RECV: begin
                // rem==1 means this beat's low word is the last one; the
                // upper half of an odd-count final beat is dropped.
                if (hs) begin
                    state_next = (rem == KNN_CNT_W'(1)) ? FIN : HI;
                end
            end
            HI: begin
                state_next = (rem == KNN_CNT_W'(1)) ? FIN : RECV;
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output / write-intent logic
    always_comb begin
        in_ready = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        case (state)
            RECV: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en   = 1'b1;
                    wr_data = in_data[DataWidth-1:0];
                end
            end
            HI: begin
                wr_en   = 1'b1;
                wr_data = hold;
            end
            default: begin
            end
        endcase
    end

    // Datapath and registered outputs. Everything here lags the FSM by one
    // cycle, which is why done lands the cycle after FIN and directly after
    // the last mem_we0 cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_address0  <= '0;
            mem_ce0       <= 1'b0;
            mem_we0       <= 1'b0;
            mem_d0        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            words_written <= '0;
            rem           <= '0;
            wr_ptr        <= '0;
            hold          <= '0;
`ifdef KNN_LOADER_CHECKSUM_EN
            checksum      <= '0;
`endif
        end else begin
            mem_we0 <= wr_en;
            mem_ce0 <= wr_en;
            done    <= (state == FIN);
            busy    <= (state != IDLE) || start_acc;

            if (wr_en) begin
                mem_address0 <= wr_ptr;
                mem_d0       <= wr_data;
            end

            if (hs) begin
                hold <= in_data[2*DataWidth-1:DataWidth];
            end

            // start_acc only in IDLE, wr_en only in RECV/HI: never together.
            if (start_acc) begin
                rem           <= num_clamped;
                wr_ptr        <= '0;
                words_written <= '0;
`ifdef KNN_LOADER_CHECKSUM_EN
                checksum      <= '0;
`endif
            end else if (wr_en) begin
                rem           <= rem - KNN_CNT_W'(1);
                wr_ptr        <= wr_ptr + AddrWidth'(1);
                words_written <= words_written + KNN_CNT_W'(1);
`ifdef KNN_LOADER_CHECKSUM_EN
                checksum      <= checksum ^ wr_data;
`endif
            end
        end
    end

endmodule

// File: tb/tb_knn_local_buf_loader.sv
// tb_knn_local_buf_loader
//   Directed bench for knn_local_buf_loader. A scoreboard queue holds the
//   expected {address, data} of every buffer write in order; a negedge
//   monitor pops it on each mem_we0 cycle. Define KNN_LOADER_CHECKSUM_EN to
//   also cover the checksum output.
module tb_knn_local_buf_loader;
    import knn_buf_pkg::*;

    localparam int EW = KNN_BUF_AW + KNN_BUF_WORD_W;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [11:0]  num_words = '0;
    logic [511:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [10:0]  mem_address0;
    logic         mem_ce0;
    logic         mem_we0;
    logic [255:0] mem_d0;
    logic         busy;
    logic         done;
    logic [11:0]  words_written;
`ifdef KNN_LOADER_CHECKSUM_EN
    logic [255:0] checksum;
`endif
    knn_state_e   state_dbg;

    always #5 clk = ~clk;

    knn_local_buf_loader dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .num_words     (num_words),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mem_address0  (mem_address0),
        .mem_ce0       (mem_ce0),
        .mem_we0       (mem_we0),
        .mem_d0        (mem_d0),
        .busy          (busy),
        .done          (done),
        .words_written (words_written),
`ifdef KNN_LOADER_CHECKSUM_EN
        .checksum      (checksum),
`endif
        .state_dbg     (state_dbg)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int run_wr = 0;
    int first_wr_cyc = 0;
    int last_wr_cyc = 0;
    int start_cyc = 0;
    bit rdy_seen = 1'b0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (in_ready) rdy_seen = 1'b1;
        if (mem_we0) begin
            check("ce_eq_we", mem_ce0, 1);
            if (exp_q.size() == 0) begin
                check("unexpected_write_q", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", mem_address0, e[EW-1:256]);
                check("wr_data", mem_d0, e[255:0]);
            end
            if (run_wr == 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            run_wr++;
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [255:0] mk_word(input int tag, input int idx);
        logic [31:0] v;
        v = 32'(tag) * 32'h10000 + 32'(idx) + 32'd1;
        return {v ^ 32'hA5A5A5A5, {6{v}}, ~v};
    endfunction

    task automatic push_exp(input int addr, input logic [255:0] d);
        exp_q.push_back({11'(addr), d});
    endtask

    task automatic start_load(input logic [11:0] n);
        start     = 1'b1;
        num_words = n;
        start_cyc = cyc;
        run_wr    = 0;
        rdy_seen  = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offers one beat and returns #1 after the edge it transferred on.
    task automatic send_beat(input logic [511:0] d, input bit keep_valid);
        int n;
        bit r;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!r && n < 300);
        if (!r) check("hs_timeout", r, 1);
        if (!keep_valid) in_valid = 1'b0;
    endtask

    // Full load: eff is the post-clamp count; gaps drop in_valid between
    // beats, and noisy raises start during those gaps.
    task automatic load(input int tag, input int n, input int eff, input int gap_max, input bit noisy);
        int beats;
        int g;
        logic [255:0] lo;
        logic [255:0] hi;
        start_load(12'(n));
        beats = (eff + 1) / 2;
        for (int i = 0; i < beats; i++) begin
            lo = mk_word(tag, 2 * i);
            hi = mk_word(tag, 2 * i + 1);
            if (2 * i < eff) push_exp(2 * i, lo);
            if (2 * i + 1 < eff) push_exp(2 * i + 1, hi);
            if (i > 0 && gap_max > 0) begin
                g = $urandom_range(0, gap_max);
                in_valid = 1'b0;
                repeat (g) begin
                    start     = noisy;
                    num_words = 12'd1;
                    @(posedge clk); #1;
                    start = 1'b0;
                end
            end
            send_beat({hi, lo}, i < beats - 1);
        end
    endtask

    // Returns at the negedge inside the done cycle.
    task automatic wait_done(input string tag, input int exp_words);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (n < 5000 && !seen) begin
            @(negedge clk);
            seen = done;
            n++;
        end
        check({tag, "_done_seen"}, seen, 1);
        if (seen) begin
            check({tag, "_words_written"}, words_written, exp_words);
            check({tag, "_busy_at_done"}, busy, 1);
            check({tag, "_q_empty"}, exp_q.size(), 0);
            check({tag, "_wr_count"}, run_wr, exp_words);
            if (exp_words > 0) check({tag, "_done_latency"}, cyc - last_wr_cyc, 1);
            else check({tag, "_done_after_start"}, cyc - start_cyc, 2);
        end
    endtask

    task automatic post_done(input string tag);
        @(negedge clk);
        check({tag, "_done_pulse_1cyc"}, done, 0);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, mem_we0, 0);
        check({tag, "_ce"}, mem_ce0, 0);
        check({tag, "_addr"}, mem_address0, 0);
        check({tag, "_d"}, mem_d0, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ww"}, words_written, 0);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_state"}, state_dbg, IDLE);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_all_zero("rst");

        // T1: 4 words, valid held high; then a start during the done cycle.
        load(1, 4, 4, 0, 1'b0);
        wait_done("t1", 4);
        check("t1_consecutive", last_wr_cyc - first_wr_cyc, 3);
        start     = 1'b1;
        num_words = 12'd2;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("t1_start_on_done_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("t1_start_on_done_state", state_dbg, IDLE);
        check("t1_ww_holds", words_written, 4);

        // T2: odd count, upper half of the second beat never written.
        load(2, 3, 3, 0, 1'b0);
        wait_done("t2", 3);
        post_done("t2");

        // T3: zero words.
        start_load(12'd0);
        wait_done("t3", 0);
        check("t3_no_ready", rdy_seen, 0);
        post_done("t3");

        // T4: clamp to the full buffer depth.
        load(3, 3000, 2048, 0, 1'b0);
        wait_done("t4", 2048);
        check("t4_last_addr", mem_address0, 2047);
        post_done("t4");

        // T5: in_valid gaps and start pulses while busy.
        load(4, 10, 10, 3, 1'b1);
        wait_done("t5", 10);
        post_done("t5");

        // T6: reset mid-load right after the fifth write is registered.
        start_load(12'd20);
        for (int i = 0; i < 5; i++) push_exp(i, mk_word(5, i));
        send_beat({mk_word(5, 1), mk_word(5, 0)}, 1'b1);
        send_beat({mk_word(5, 3), mk_word(5, 2)}, 1'b1);
        send_beat({mk_word(5, 5), mk_word(5, 4)}, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("t6_rst");
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_q_empty", exp_q.size(), 0);
        check("t6_idle_busy", busy, 0);
        @(posedge clk); #1;
        load(7, 2, 2, 0, 1'b0);
        wait_done("t6b", 2);
        post_done("t6b");

`ifdef KNN_LOADER_CHECKSUM_EN
        // T7: checksum of 0x1, 0x2, 0x4.
        @(posedge clk); #1;
        start_load(12'd3);
        push_exp(0, 256'h1);
        push_exp(1, 256'h2);
        push_exp(2, 256'h4);
        send_beat({256'h2, 256'h1}, 1'b1);
        send_beat({256'h0, 256'h4}, 1'b0);
        wait_done("t7", 3);
        check("t7_checksum", checksum, 256'h7);
        post_done("t7");
        check("t7_checksum_stable", checksum, 256'h7);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
